ym3438_slot_timer: RTL and testbench
====================================

YM3438_SLOT_TIMER -- requirements
Module: ym3438_slot_timer

Interface
REQ-001 SHALL have parameter C1_PERIOD, default 12: expected MCLK cycles between consecutive c1 rising edges.
REQ-002 SHALL have port MCLK, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port IC, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port c1, input, 1: phase-1 clock level from the prescaler, sampled on MCLK.
REQ-005 SHALL have port c2, input, 1: phase-2 clock level from the prescaler, sampled on MCLK.
REQ-006 SHALL have port reset_fsm, input, 1: slot-counter resynchronisation request from the prescaler.
REQ-007 SHALL have port slot, output, 5: current slot, range 0..23.
REQ-008 SHALL have port chan, output, 3: slot mod 6, range 0..5.
REQ-009 SHALL have port op, output, 2: slot div 6, range 0..3.
REQ-010 SHALL have port frame_sync, output, 1: one-MCLK pulse on natural wrap 23->0.
REQ-011 SHALL have port locked, output, 1: two full frames completed since the last resync.
REQ-012 SHALL have port clk_err, output, 1: sticky c1/c2 overlap error.
REQ-013 SHALL have port period_err, output, 1: sticky c1 period error.

Function
REQ-014 SHALL register c1 and c2 once (c1_q, c2_q) and define step = c1 & ~c1_q (c1 rising edge).
REQ-015 SHALL, on step with reset_fsm=1, load slot=0 without asserting frame_sync.
REQ-016 SHALL, on step with reset_fsm=0, set slot=0 if slot==23, else slot+1.
REQ-017 SHALL hold slot, chan and op when step=0, regardless of reset_fsm.
REQ-018 SHALL register chan and op and update them in the same MCLK edge as slot, never combinationally from slot.
REQ-019 SHALL pulse frame_sync high for exactly the one MCLK cycle following a step that wraps slot 23->0 with reset_fsm=0.
REQ-020 SHALL keep a 2-bit saturating wrap counter, cleared by a step with reset_fsm=1, incremented on each natural wrap; locked = (count==2).
REQ-021 SHALL set clk_err on any MCLK edge where c1 and c2 are both 1, and hold it until IC.
REQ-022 SHALL keep a 5-bit saturating interval counter, cleared to 1 on step and incremented otherwise.
REQ-023 SHALL on each step, except the first step after IC, set period_err if the interval counter != C1_PERIOD, and hold it until IC.
REQ-024 SHALL treat a saturated interval counter (31) as a mismatch at the next step.
REQ-025 SHALL give priority to the reset_fsm resync over a natural wrap when both occur on the same step.
REQ-026 SHALL not clear clk_err or period_err on reset_fsm.

Reset
REQ-027 SHALL, while IC=0, asynchronously force slot=0, chan=0, op=0, frame_sync=0, locked=0, clk_err=0, period_err=0, c1_q=0, c2_q=0, wrap count=0, interval=0 and first-step flag=1.
REQ-028 SHALL resume operation on the first MCLK edge after IC deasserts; an IC assertion mid-frame SHALL abandon the frame with no frame_sync.

Verification
REQ-029 SHALL show: IC low then high, reset_fsm step, then 24 clean steps at period 12 -> slot 0..23 then 0, one frame_sync at the wrap, chan/op track (slot 13 -> chan 1, op 2), period_err=0.
REQ-030 SHALL show: 48 clean steps after a resync -> locked=1 one MCLK after the second wrap; a further reset_fsm step -> slot=0, locked=0, no frame_sync.
REQ-031 SHALL show: reset_fsm=1 on the step taken at slot 23 -> slot=0, frame_sync stays 0, wrap count cleared.
REQ-032 SHALL show: c1=c2=1 for one MCLK -> clk_err=1, persisting through a reset_fsm step until IC low.
REQ-033 SHALL show: one c1 interval of 11 MCLK -> period_err=1 at that step; a 40-MCLK gap -> period_err=1 (saturation); the first step after IC never flags.
REQ-034 SHALL show: IC asserted at slot 17 with c1 high -> all outputs 0 immediately (asynchronously), then a clean restart from slot 0.

Source files
------------

// File: rtl/ym3438_slot_timer.sv
// ym3438_slot_timer
//   Slot sequencer for the YM3438 operator pipeline. Advances a 0..23 slot
//   counter on every rising edge of the prescaler phase-1 clock, and derives
//   the channel (slot mod 6) and operator (slot div 6) indices. It also
//   reports frame boundaries, frame lock, and clock-health errors.
//
// Parameters
//   C1_PERIOD   expected MCLK cycles between consecutive c1 rising edges
//
// Ports
//   MCLK        in   master clock; all state updates on its rising edge
//   IC          in   asynchronous active-low reset
//   c1, c2      in   prescaler phase-1 / phase-2 levels, sampled on MCLK
//   reset_fsm   in   resynchronise the slot counter to 0 on the next c1 step
//   slot        out  current slot, 0..23
//   chan        out  slot mod 6, 0..5
//   op          out  slot div 6, 0..3
//   frame_sync  out  one-MCLK pulse after a natural 23->0 wrap
//   locked      out  two full frames completed since the last resync
//   clk_err     out  sticky: c1 and c2 observed high together
//   period_err  out  sticky: c1 rising-edge spacing differed from C1_PERIOD
module ym3438_slot_timer #(
  parameter int C1_PERIOD = 12
) (
  input  logic       MCLK,
  input  logic       IC,
  input  logic       c1,
  input  logic       c2,
  input  logic       reset_fsm,
  output logic [4:0] slot,
  output logic [2:0] chan,
  output logic [1:0] op,
  output logic       frame_sync,
  output logic       locked,
  output logic       clk_err,
  output logic       period_err
);

  localparam logic [4:0] PERIOD    = 5'(C1_PERIOD);
  localparam logic [4:0] INTVL_SAT = 5'd31;
  localparam logic [4:0] LAST_SLOT = 5'd23;

  logic       c1_q, c1_d;
  logic       c2_q, c2_d;
  logic [4:0] slot_q, slot_d;
  logic [2:0] chan_q, chan_d;
  logic [1:0] op_q, op_d;
  logic       frame_sync_q, frame_sync_d;
  logic [1:0] wrap_cnt_q, wrap_cnt_d;
  logic       locked_q, locked_d;
  logic       clk_err_q, clk_err_d;
  logic       period_err_q, period_err_d;
  logic [4:0] interval_q, interval_d;
  logic       first_q, first_d;
  logic       step;

  always_comb begin
    step         = c1 & ~c1_q;
    c1_d         = c1;
    c2_d         = c2;
    slot_d       = slot_q;
    chan_d       = chan_q;
    op_d         = op_q;
    frame_sync_d = 1'b0;
    wrap_cnt_d   = wrap_cnt_q;
    first_d      = first_q;
    period_err_d = period_err_q;
    // A registered overlap implies the raw pair overlapped one edge earlier,
    // so both terms describe the same fault; either sets the sticky flag.
    clk_err_d    = clk_err_q | (c1 & c2) | (c1_q & c2_q);
    interval_d   = (interval_q == INTVL_SAT) ? INTVL_SAT : interval_q + 5'd1;

    if (step) begin
      interval_d = 5'd1;
      first_d    = 1'b0;
      // The first step after IC has no previous edge to measure against.
      // A saturated interval is always a mismatch, even if C1_PERIOD is 31.
      if (!first_q && ((interval_q == INTVL_SAT) || (interval_q != PERIOD)))
        period_err_d = 1'b1;

      if (reset_fsm) begin
        // Resync wins over a coincident natural wrap: no frame_sync.
        slot_d     = 5'd0;
        chan_d     = 3'd0;
        op_d       = 2'd0;
        wrap_cnt_d = 2'd0;
      end else if (slot_q == LAST_SLOT) begin
        slot_d       = 5'd0;
        chan_d       = 3'd0;
        op_d         = 2'd0;
        frame_sync_d = 1'b1;
        if (wrap_cnt_q != 2'd2)
          wrap_cnt_d = wrap_cnt_q + 2'd1;
      end else begin
        // chan/op follow slot incrementally so they change on the same edge.
        slot_d = slot_q + 5'd1;
        if (chan_q == 3'd5) begin
          chan_d = 3'd0;
          op_d   = op_q + 2'd1;
        end else begin
          chan_d = chan_q + 3'd1;
        end
      end
    end

    locked_d = (wrap_cnt_d == 2'd2);
  end

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      c1_q         <= 1'b0;
      c2_q         <= 1'b0;
      slot_q       <= 5'd0;
      chan_q       <= 3'd0;
      op_q         <= 2'd0;
      frame_sync_q <= 1'b0;
      wrap_cnt_q   <= 2'd0;
      locked_q     <= 1'b0;
      clk_err_q    <= 1'b0;
      period_err_q <= 1'b0;
      interval_q   <= 5'd0;
      first_q      <= 1'b1;
    end else begin
      c1_q         <= c1_d;
      c2_q         <= c2_d;
      slot_q       <= slot_d;
      chan_q       <= chan_d;
      op_q         <= op_d;
      frame_sync_q <= frame_sync_d;
      wrap_cnt_q   <= wrap_cnt_d;
      locked_q     <= locked_d;
      clk_err_q    <= clk_err_d;
      period_err_q <= period_err_d;
      interval_q   <= interval_d;
      first_q      <= first_d;
    end
  end

  assign slot       = slot_q;
  assign chan       = chan_q;
  assign op         = op_q;
  assign frame_sync = frame_sync_q;
  assign locked     = locked_q;
  assign clk_err    = clk_err_q;
  assign period_err = period_err_q;

endmodule

// File: tb/tb_ym3438_slot_timer.sv
// Testbench for ym3438_slot_timer: table-driven step vectors, hand-written
// corner sequences, and a randomized run checked every MCLK against a
// behavioural slot/frame model.
module tb_ym3438_slot_timer;

  localparam int C1_PERIOD = 12;

  logic       MCLK = 1'b0;
  logic       IC = 1'b0;
  logic       c1 = 1'b0;
  logic       c2 = 1'b0;
  logic       reset_fsm = 1'b0;
  logic [4:0] slot;
  logic [2:0] chan;
  logic [1:0] op;
  logic       frame_sync;
  logic       locked;
  logic       clk_err;
  logic       period_err;

  ym3438_slot_timer #(.C1_PERIOD(C1_PERIOD)) dut (
    .MCLK(MCLK), .IC(IC), .c1(c1), .c2(c2), .reset_fsm(reset_fsm),
    .slot(slot), .chan(chan), .op(op), .frame_sync(frame_sync),
    .locked(locked), .clk_err(clk_err), .period_err(period_err)
  );

  always #5 MCLK = ~MCLK;

  int n_tests = 0;
  int n_fail  = 0;
  int fs_seen = 0;

  // Behavioural model: slot as an integer, frames counted, errors sticky.
  int m_slot, m_frames, m_cycle, m_last_step;
  bit m_c1_prev, m_fs, m_clk_err, m_perr, m_first;

  typedef struct {
    bit rf;
    int period;
    int slot;
    int chan;
    int op;
    bit fs;
    bit perr;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_slot = 0; m_frames = 0; m_cycle = 0; m_last_step = 0;
    m_c1_prev = 0; m_fs = 0; m_clk_err = 0; m_perr = 0; m_first = 1;
  endtask

  task automatic model_clock(input bit a1, input bit a2, input bit rf);
    m_cycle++;
    m_fs = 0;
    if (a1 && a2) m_clk_err = 1;
    if (a1 && !m_c1_prev) begin
      if (!m_first && (m_cycle - m_last_step) != C1_PERIOD) m_perr = 1;
      m_first = 0;
      m_last_step = m_cycle;
      if (rf) begin
        m_slot = 0; m_frames = 0;
      end else if (m_slot == 23) begin
        m_slot = 0; m_fs = 1;
        if (m_frames < 2) m_frames++;
      end else begin
        m_slot++;
      end
    end
    m_c1_prev = a1;
  endtask

  task automatic check_model();
    check("slot", int'(slot), m_slot);
    check("chan", int'(chan), m_slot % 6);
    check("op", int'(op), m_slot / 6);
    check("frame_sync", int'(frame_sync), int'(m_fs));
    check("locked", int'(locked), (m_frames == 2) ? 1 : 0);
    check("clk_err", int'(clk_err), int'(m_clk_err));
    check("period_err", int'(period_err), int'(m_perr));
  endtask

  task automatic tick(input bit a1, input bit a2, input bit rf);
    c1 = a1; c2 = a2; reset_fsm = rf;
    @(posedge MCLK);
    #1;
    model_clock(a1, a2, rf);
    if (frame_sync) fs_seen++;
    check_model();
  endtask

  // c1 low for period-1 cycles then high for one: rises are exactly
  // `period` MCLK apart regardless of the previous call.
  task automatic pulse(input bit rf, input int period);
    for (int i = 0; i < period; i++)
      tick(i == period - 1, (i == period / 2) && (i != period - 1), rf);
  endtask

  task automatic steps(input int n);
    repeat (n) pulse(1'b0, C1_PERIOD);
  endtask

  // Assert IC away from the clock edge, check the asynchronous clear, hold
  // for two edges, then release.
  task automatic do_reset();
    #2 IC = 1'b0;
    #1;
    check("rst_async_slot", int'(slot), 0);
    check("rst_async_chan", int'(chan), 0);
    check("rst_async_op", int'(op), 0);
    check("rst_async_fs", int'(frame_sync), 0);
    check("rst_async_locked", int'(locked), 0);
    check("rst_async_clk_err", int'(clk_err), 0);
    check("rst_async_perr", int'(period_err), 0);
    c1 = 1'b0; c2 = 1'b0; reset_fsm = 1'b0;
    repeat (2) @(posedge MCLK);
    #1;
    model_reset();
    check_model();
    IC = 1'b1;
    fs_seen = 0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 12, 0, 0, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 12, 1, 1, 0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 12, 2, 2, 0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 12, 3, 3, 0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 12, 4, 4, 0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 12, 5, 5, 0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 12, 6, 0, 1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 12, 7, 1, 1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 12, 0, 0, 0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 12, 1, 1, 0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 11, 2, 2, 0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 12, 3, 3, 0, 1'b0, 1'b1};

    do_reset();

    // Table-driven steps.
    for (int k = 0; k < 12; k++) begin
      pulse(tbl[k].rf, tbl[k].period);
      check($sformatf("vec%0d_slot", k), int'(slot), tbl[k].slot);
      check($sformatf("vec%0d_chan", k), int'(chan), tbl[k].chan);
      check($sformatf("vec%0d_op", k), int'(op), tbl[k].op);
      check($sformatf("vec%0d_fs", k), int'(frame_sync), int'(tbl[k].fs));
      check($sformatf("vec%0d_perr", k), int'(period_err), int'(tbl[k].perr));
    end

    // Clean frame after resync: 0..23 then 0, one frame_sync.
    do_reset();
    pulse(1'b1, C1_PERIOD);
    fs_seen = 0;
    for (int s = 1; s <= 24; s++) begin
      pulse(1'b0, C1_PERIOD);
      if (s == 13) begin
        check("s13_chan", int'(chan), 1);
        check("s13_op", int'(op), 2);
      end
      check("frame_slot", int'(slot), s % 24);
    end
    check("fs_at_wrap", int'(frame_sync), 1);
    tick(1'b0, 1'b0, 1'b0);
    check("fs_one_cycle", int'(frame_sync), 0);
    check("fs_count", fs_seen, 1);
    check("perr_clean", int'(period_err), 0);
    check("locked_one_frame", int'(locked), 0);

    // Second frame -> locked; resync clears it.
    pulse(1'b0, C1_PERIOD - 1);
    steps(22);
    check("pre_lock_slot", int'(slot), 23);
    check("pre_lock", int'(locked), 0);
    pulse(1'b0, C1_PERIOD);
    check("locked_after_2", int'(locked), 1);
    check("fs_wrap2", int'(frame_sync), 1);
    pulse(1'b1, C1_PERIOD);
    check("resync_slot", int'(slot), 0);
    check("resync_unlock", int'(locked), 0);
    check("resync_no_fs", int'(frame_sync), 0);

    // Resync on the step at slot 23 beats the wrap and clears wrap count.
    steps(24);
    check("one_wrap_unlocked", int'(locked), 0);
    steps(23);
    check("at23", int'(slot), 23);
    fs_seen = 0;
    pulse(1'b1, C1_PERIOD);
    check("rf23_slot", int'(slot), 0);
    check("rf23_no_fs", fs_seen, 0);
    steps(24);
    check("cnt_cleared_locked", int'(locked), 0);
    check("cnt_cleared_fs", int'(frame_sync), 1);

    // c1/c2 overlap: sticky through resync, cleared by IC.
    tick(1'b1, 1'b1, 1'b0);
    check("clk_err_set", int'(clk_err), 1);
    pulse(1'b1, C1_PERIOD - 1);
    check("clk_err_hold", int'(clk_err), 1);
    check("clk_err_rf_slot", int'(slot), 0);
    check("clk_err_no_perr", int'(period_err), 0);
    do_reset();
    check("clk_err_cleared", int'(clk_err), 0);

    // Period errors: first step never flags; short, long and saturating gaps.
    pulse(1'b1, 40);
    check("first_step_noflag", int'(period_err), 0);
    pulse(1'b0, C1_PERIOD);
    check("good_period", int'(period_err), 0);
    pulse(1'b0, 40);
    check("gap40_perr", int'(period_err), 1);
    pulse(1'b1, C1_PERIOD);
    check("perr_survives_rf", int'(period_err), 1);
    do_reset();
    pulse(1'b1, C1_PERIOD);
    pulse(1'b0, 44);
    check("gap44_sat_perr", int'(period_err), 1);
    do_reset();
    pulse(1'b0, C1_PERIOD);
    check("first_rf0_slot", int'(slot), 1);
    pulse(1'b0, C1_PERIOD - 1);
    check("short_perr", int'(period_err), 1);
    check("short_slot", int'(slot), 2);

    // IC mid-frame at slot 17 with c1 high.
    do_reset();
    pulse(1'b1, C1_PERIOD);
    steps(17);
    check("at17", int'(slot), 17);
    check("c1_high", int'(c1), 1);
    do_reset();
    pulse(1'b1, C1_PERIOD);
    check("restart_slot0", int'(slot), 0);
    pulse(1'b0, C1_PERIOD);
    check("restart_slot1", int'(slot), 1);
    check("restart_no_fs", fs_seen, 0);

    // Randomized run against the model.
    do_reset();
    for (int p = 0; p < 400; p++) begin
      int period;
      if (p == 200) do_reset();
      period = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 45)) : C1_PERIOD;
      for (int i = 0; i < period; i++) begin
        bit a1, a2, rf;
        a1 = (i == period - 1);
        a2 = ($urandom_range(0, 299) == 0) ? 1'b1 : ((i == period / 2) && (i != period - 1));
        rf = (i == period - 1) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 1);
        tick(a1, a2, rf);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
